// File: rtl/oper_gen_pkg.sv
// oper_gen shared definitions: mover command codes and bounce FSM states.
// Shared with the position mover and the PicoBlaze port decoder.
package oper_gen_pkg;

  localparam int POS_W = 10;

  localparam logic [1:0] OPER_NOP = 2'b00;
  localparam logic [1:0] OPER_DEC = 2'b01;
  localparam logic [1:0] OPER_INC = 2'b10;

  typedef enum logic [1:0] {
    S_RIGHT   = 2'd0,
    S_LEFT    = 2'd1,
    S_DWELL_R = 2'd2,
    S_DWELL_L = 2'd3
  } state_e;

endpackage

// File: rtl/oper_gen_btn_sync_edge.sv
// Two-flop synchroniser for a raw push-button plus a rising-edge pulse.
// The pulse is decoded from flopped bits only, so it is glitch-free.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [2:0] s_q, s_d;

  always_comb s_d = {s_q[1:0], btn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= '0;
    else        s_q <= s_d;
  end

  assign pulse = s_q[1] & ~s_q[2];

endmodule

// File: rtl/oper_gen.sv
// oper_gen: INC/DEC/NOP command source for the position mover (auto/manual).
// Define OPER_GEN_DWELL_EN to hold DWELL_TICKS ticks at each end of the bounce.
module oper_gen
  import oper_gen_pkg::*;
#(
  parameter int N           = 4,
  parameter int M           = 15,
  parameter int TICK_DIV    = 5000000,
  parameter int DIV_W       = 23,
  parameter int DWELL_TICKS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             btn_right,
  input  logic             btn_left,
  input  logic [POS_W-1:0] pos,
  output logic [1:0]       oper,
  output logic             dir,
  output logic             tick
);

  if (TICK_DIV < 2 || M <= N || DWELL_TICKS < 1) begin : g_bad_cfg
    $error("oper_gen: invalid parameters");
  end

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [1:0]       oper_q, oper_d;
  logic             dir_q, dir_d;
  state_e           state_q, state_d;
  logic             r_pulse, l_pulse;
  logic             at_max, at_min;

  btn_sync_edge u_sync_r (
    .clk   (clk),
    .rst_n (reset),
    .btn   (btn_right),
    .pulse (r_pulse)
  );

  btn_sync_edge u_sync_l (
    .clk   (clk),
    .rst_n (reset),
    .btn   (btn_left),
    .pulse (l_pulse)
  );

  assign at_max = pos >= POS_W'(M);
  assign at_min = pos <= POS_W'(N);

`ifdef OPER_GEN_DWELL_EN
  localparam int DW_W = $clog2(DWELL_TICKS + 1);
  logic [DW_W-1:0] dwell_q, dwell_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dwell_q <= '0;
    else        dwell_q <= dwell_d;
  end
`endif

  always_comb begin
    cnt_d   = '0;
    tick_d  = 1'b0;
    oper_d  = OPER_NOP;
    dir_d   = dir_q;
    state_d = state_q;
`ifdef OPER_GEN_DWELL_EN
    dwell_d = dwell_q;
`endif

    if (en && !mode) begin
      if (cnt_q == DIV_W'(TICK_DIV - 1)) tick_d = 1'b1;
      else cnt_d = cnt_q + DIV_W'(1);
    end

    // a step is never issued back-to-back: pos must settle first
    if (en && oper_q == OPER_NOP) begin
      if (mode) begin
        if (r_pulse && !l_pulse && !at_max) oper_d = OPER_INC;
        else if (l_pulse && !r_pulse && !at_min) oper_d = OPER_DEC;
      end else if (tick_q) begin
        case (state_q)
          S_RIGHT: begin
            if (at_max) begin
`ifdef OPER_GEN_DWELL_EN
              state_d = S_DWELL_R;
              dwell_d = DW_W'(1);
`else
              state_d = S_LEFT;
              dir_d   = 1'b0;
              oper_d  = OPER_DEC;
`endif
            end else begin
              oper_d = OPER_INC;
            end
          end
          S_LEFT: begin
            if (at_min) begin
`ifdef OPER_GEN_DWELL_EN
              state_d = S_DWELL_L;
              dwell_d = DW_W'(1);
`else
              state_d = S_RIGHT;
              dir_d   = 1'b1;
              oper_d  = OPER_INC;
`endif
            end else begin
              oper_d = OPER_DEC;
            end
          end
`ifdef OPER_GEN_DWELL_EN
          S_DWELL_R: begin
            if (dwell_q >= DW_W'(DWELL_TICKS)) begin
              state_d = S_LEFT;
              dir_d   = 1'b0;
              oper_d  = OPER_DEC;
            end else begin
              dwell_d = dwell_q + DW_W'(1);
            end
          end
          S_DWELL_L: begin
            if (dwell_q >= DW_W'(DWELL_TICKS)) begin
              state_d = S_RIGHT;
              dir_d   = 1'b1;
              oper_d  = OPER_INC;
            end else begin
              dwell_d = dwell_q + DW_W'(1);
            end
          end
`endif
          default: begin
            state_d = S_RIGHT;
            dir_d   = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      oper_q  <= OPER_NOP;
      dir_q   <= 1'b1;
      state_q <= S_RIGHT;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      oper_q  <= oper_d;
      dir_q   <= dir_d;
      state_q <= state_d;
    end
  end

  assign oper = oper_q;
  assign dir  = dir_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_oper_gen.sv
// Bench for oper_gen: mover model, auto bounce, reset, en/mode and manual buttons.
// Built with N=4, M=15, TICK_DIV=4.
module tb_oper_gen;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] DEC = 2'b01;
  localparam logic [1:0] INC = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_left = 1'b0;
  logic [9:0] pos = 10'd0;
  logic [1:0] oper;
  logic       dir;
  logic       tick;

  logic       ld = 1'b0;
  logic [9:0] ld_val = 10'd0;
  logic       mon_on = 1'b0;
  logic [1:0] prev_oper = 2'b00;
  int         checks = 0;
  int         errors = 0;
  int         viol = 0;

  typedef struct {
    string      nm;
    logic [9:0] p;
    logic       r;
    logic       l;
    logic [1:0] exp;
  } mvec_t;

  mvec_t tv[11];

  oper_gen #(
    .N(4), .M(15), .TICK_DIV(4), .DIV_W(3), .DWELL_TICKS(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .btn_right (btn_right),
    .btn_left  (btn_left),
    .pos       (pos),
    .oper      (oper),
    .dir       (dir),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) pos <= ld_val;
    else if (oper == INC) pos <= pos + 10'd1;
    else if (oper == DEC) pos <= pos - 10'd1;
  end

  always @(negedge clk) begin
    if (reset && ((oper == 2'b11) ||
        (prev_oper != NOP && oper != NOP) ||
        (mon_on && (pos < 10'd4 || pos > 10'd15))))
      viol <= viol + 1;
    prev_oper <= oper;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_pos(input logic [9:0] v);
    ld = 1'b1;
    ld_val = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 50);
  endtask

  task automatic wait_op(output logic [1:0] op, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (oper == NOP && n < 50);
    op = oper;
  endtask

  initial begin
    int n;
    int cnt;
    logic [1:0] op;
    logic [1:0] cap;
    logic [1:0] exp;

    tv[0]  = '{"r_at_max",   10'd15, 1'b1, 1'b0, NOP};
    tv[1]  = '{"l_at_max",   10'd15, 1'b0, 1'b1, DEC};
    tv[2]  = '{"l_at_min",   10'd4,  1'b0, 1'b1, NOP};
    tv[3]  = '{"r_at_min",   10'd4,  1'b1, 1'b0, INC};
    tv[4]  = '{"r_mid",      10'd10, 1'b1, 1'b0, INC};
    tv[5]  = '{"l_mid",      10'd10, 1'b0, 1'b1, DEC};
    tv[6]  = '{"both_mid",   10'd10, 1'b1, 1'b1, NOP};
    tv[7]  = '{"r_above",    10'd16, 1'b1, 1'b0, NOP};
    tv[8]  = '{"l_below",    10'd3,  1'b0, 1'b1, NOP};
    tv[9]  = '{"r_below_mx", 10'd14, 1'b1, 1'b0, INC};
    tv[10] = '{"l_above_mn", 10'd5,  1'b0, 1'b1, DEC};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_oper", oper, NOP);
    chk("rst_dir", dir, 1);
    chk("rst_tick", tick, 0);

    // first tick after release
    load_pos(10'd10);
    en = 1'b1;
    mode = 1'b0;
    reset = 1'b1;
    wait_tick(n);
    chk("first_tick_lat", n, 4);

    // auto bounce from 10: 5 INC, 11 DEC, then INC again
    mon_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_op(op, n);
      exp = (i < 5 || i >= 16) ? INC : DEC;
      chk($sformatf("bounce_op%0d", i), op, exp);
      if (i > 0) chk($sformatf("bounce_gap%0d", i), n, 4);
    end
    mon_on = 1'b0;
    chk("bounce_dir_end", dir, 1);

    // reverse at M, then async reset with a step on the output
    load_pos(10'd15);
    wait_op(op, n);
    chk("rev_at_max_op", op, DEC);
    chk("rev_at_max_dir", dir, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_oper", oper, NOP);
    chk("async_rst_dir", dir, 1);
    chk("async_rst_tick", tick, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    wait_tick(n);
    chk("rst_release_tick_lat", n, 4);

    // pos stayed 15 (reset killed the pending step): reverses again
    wait_op(op, n);
    chk("post_rst_op", op, DEC);
    chk("post_rst_dir", dir, 0);

    // drop en in the decision cycle
    wait_tick(n);
    chk("pre_en_tick", tick, 1);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_oper", oper, NOP);
    repeat (3) @(negedge clk);
    chk("en_off_pos", pos, 14);
    chk("en_off_tick", tick, 0);
    en = 1'b1;
    wait_tick(n);
    chk("en_on_tick_lat", n, 4);
    wait_op(op, n);
    chk("en_on_op", op, DEC);
    chk("en_on_op_lat", n, 1);

    // manual mode vectors
    mode = 1'b1;
    foreach (tv[k]) begin
      load_pos(tv[k].p);
      repeat (3) @(negedge clk);
      btn_right = tv[k].r;
      btn_left = tv[k].l;
      cnt = 0;
      cap = NOP;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (c == 3) cap = oper;
        if (oper != NOP) cnt++;
      end
      chk({tv[k].nm, "_oper"}, cap, tv[k].exp);
      chk({tv[k].nm, "_pulses"}, cnt, (tv[k].exp != NOP) ? 1 : 0);
      btn_right = 1'b0;
      btn_left = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("manual_dir_kept", dir, 0);

    // back to auto: resumes leftward
    mode = 1'b0;
    load_pos(10'd10);
    wait_op(op, n);
    chk("resume_op", op, DEC);
    chk("resume_lat", n, 4);

    chk("no_violation", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
